// File: rtl/alu_pkg.sv
// Definitions shared by the ALU request arbiter and its requesters.
package alu_pkg;

    // Default operand/result and opcode widths
    localparam int N_DEF    = 5;
    localparam int NSEL_DEF = 6;

    // Width of the ALU latency wait counter
    localparam int CNT_W = 3;

    // ALU opcodes
    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. The priority holder wins a tie; priority
// passes to the loser only when a grant is actually accepted.
module rr_arbiter2 (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       grant_valid,
    output logic       grant_id
);

    logic prio_reg;   // 0: requester 0 holds priority, 1: requester 1

    // Hand priority to the other requester whenever a grant is taken
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            prio_reg <= 1'b0;
        end else if (accept) begin
            prio_reg <= ~grant_id;
        end
    end

    // A lone requester always wins; a tie goes to the priority holder
    always_comb begin
        grant_valid = |req;
        grant_id    = (req == 2'b11) ? prio_reg : req[1];
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU between two valid/ready requesters. One operation is in
// flight at a time: accept, wait the ALU latency, capture, pulse response.
module alu_req_arbiter
    import alu_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int NSel    = NSEL_DEF,
    parameter int ALU_LAT = 1
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_req0_valid,
    output logic            o_req0_ready,
    input  logic [N-1:0]    i_req0_A,
    input  logic [N-1:0]    i_req0_B,
    input  logic [NSel-1:0] i_req0_Op,
    input  logic            i_req1_valid,
    output logic            o_req1_ready,
    input  logic [N-1:0]    i_req1_A,
    input  logic [N-1:0]    i_req1_B,
    input  logic [NSel-1:0] i_req1_Op,
    output logic [N-1:0]    o_alu_A,
    output logic [N-1:0]    o_alu_B,
    output logic [NSel-1:0] o_alu_Op,
    input  logic [N-1:0]    i_alu_Result,
    input  logic            i_alu_overflow,
    input  logic            i_alu_zero,
    output logic            o_rsp0_valid,
    output logic            o_rsp1_valid,
    output logic [N-1:0]    o_rsp_Result,
    output logic            o_rsp_overflow,
    output logic            o_rsp_zero
);

    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(ALU_LAT);

    arb_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             winner_reg;
    logic [N-1:0]     alu_a_reg, alu_b_reg;
    logic [NSel-1:0]  alu_op_reg;
    logic [N-1:0]     rsp_result_reg;
    logic             rsp_overflow_reg, rsp_zero_reg;

    logic             grant_valid, grant_id, accept, idle;
    logic [1:0]       ready_vec, rsp_vec;

    assign idle   = (state_reg == ST_IDLE);
    assign accept = idle && grant_valid;

    rr_arbiter2 u_rr (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .req         ({i_req1_valid, i_req0_valid}),
        .accept      (accept),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Per-requester ready and response strobes; at most one of each is high
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign ready_vec[gi] = accept && (grant_id == 1'(gi));
            assign rsp_vec[gi]   = (state_reg == ST_RESP) && (winner_reg == 1'(gi));
        end
    endgenerate

    assign o_req0_ready = ready_vec[0];
    assign o_req1_ready = ready_vec[1];
    assign o_rsp0_valid = rsp_vec[0];
    assign o_rsp1_valid = rsp_vec[1];

    // Sequencing state register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: accept -> wait out the ALU latency -> one response cycle
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept) state_next = ST_WAIT;
            ST_WAIT: if (cnt_reg == '0) state_next = ST_RESP;
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Latch the winner's payload on accept, count down, capture the ALU output
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cnt_reg          <= '0;
            winner_reg       <= 1'b0;
            alu_a_reg        <= '0;
            alu_b_reg        <= '0;
            alu_op_reg       <= '0;
            rsp_result_reg   <= '0;
            rsp_overflow_reg <= 1'b0;
            rsp_zero_reg     <= 1'b0;
        end else if (accept) begin
            winner_reg <= grant_id;
            cnt_reg    <= LAT_INIT;
            alu_a_reg  <= grant_id ? i_req1_A  : i_req0_A;
            alu_b_reg  <= grant_id ? i_req1_B  : i_req0_B;
            alu_op_reg <= grant_id ? i_req1_Op : i_req0_Op;
        end else if (state_reg == ST_WAIT) begin
            if (cnt_reg == '0) begin
                rsp_result_reg   <= i_alu_Result;
                rsp_overflow_reg <= i_alu_overflow;
                rsp_zero_reg     <= i_alu_zero;
            end else begin
                cnt_reg <= cnt_reg - 1'b1;
            end
        end
    end

    assign o_alu_A        = alu_a_reg;
    assign o_alu_B        = alu_b_reg;
    assign o_alu_Op       = alu_op_reg;
    assign o_rsp_Result   = rsp_result_reg;
    assign o_rsp_overflow = rsp_overflow_reg;
    assign o_rsp_zero     = rsp_zero_reg;

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
Shares one ALU instance between two requesters (e.g. switch/button front end and a UART command path) using valid/ready handshakes. Round-robin arbitration picks a request, drives the ALU operand/opcode inputs, waits a fixed ALU latency, then returns result and flags to the winning requester as a one-cycle response pulse. Sits between the requester blocks and the alu module inside the top level.

Parameters:
N, 5, operand/result width in bits
NSel, 6, opcode width in bits
ALU_LAT, 1, ALU clock cycles from operands valid at ALU inputs to result valid at ALU outputs; legal range 0..7

Ports:
i_clock  in  1  system clock, all logic on rising edge
i_reset  in  1  synchronous, active-high reset
i_req0_valid  in  1  requester 0 has an operation
o_req0_ready  out  1  requester 0 request accepted this cycle when valid&ready
i_req0_A / i_req0_B  in  N each  requester 0 operands
i_req0_Op  in  NSel  requester 0 opcode
i_req1_valid, o_req1_ready, i_req1_A, i_req1_B, i_req1_Op  same as requester 0, for requester 1
o_alu_A / o_alu_B  out  N each  registered operands to ALU
o_alu_Op  out  NSel  registered opcode to ALU
i_alu_Result  in  N  ALU result
i_alu_overflow  in  1  ALU overflow flag
i_alu_zero  in  1  ALU zero flag
o_rsp0_valid / o_rsp1_valid  out  1 each  one-cycle response strobe to requester 0/1
o_rsp_Result  out  N  captured result, shared by both requesters
o_rsp_overflow / o_rsp_zero  out  1 each  captured flags

Behaviour:
- Reset (i_reset high at a rising edge): state=IDLE, priority=req0, wait counter=0, all registered outputs (o_alu_*, o_rsp_*) = 0. Reset mid-operation discards the in-flight op; no response is issued.
- FSM states: IDLE, WAIT, RESP.
- IDLE: grant = the only valid requester, or the priority holder if both valid. o_reqX_ready = (state==IDLE) && grant==X; ready depends combinationally on valid; valid never depends on ready. At most one ready high per cycle.
- Accept edge (valid&ready): latch winner's A/B/Op into o_alu_*, record winner id, load counter=ALU_LAT, priority moves to the other requester, go to WAIT.
- WAIT: if counter==0, capture i_alu_Result/overflow/zero into o_rsp_* and go to RESP; otherwise decrement counter. Capture therefore occurs ALU_LAT+1 edges after accept.
- RESP: o_rspX_valid=1 for the recorded winner only, for exactly one cycle; o_rsp_* stable during it. Next edge returns to IDLE.
- o_alu_* hold the last issued values until next accept. o_rsp_* hold until next capture.
- Priority changes only on accept; an idle requester never starves the other. Throughput: one op per ALU_LAT+3 cycles.
- Requester dropping valid before acceptance: legal, nothing issued. Requester payload is sampled only at the accept edge.
- Widths: no arithmetic on data paths; counter is 3 bits.

Decomposition:
- Shared package alu_pkg: opcode constants (ADD=6'b100000, SUB=6'b100010, AND=6'b100100, OR=6'b100101, XOR=6'b100110, SRA=6'b000011, SRL=6'b000010, NOR=6'b100111), FSM state encodings, default N/NSel.
- One natural sub-module: rr_arbiter2 (2-way round-robin grant with priority register, update on accept strobe).

Test Plan:
- Single op: after reset, req0 valid A=5'd3, B=5'd4, Op=ADD, ALU_LAT=1 -> ready0 in cycle 0; o_alu_A=3, o_alu_B=4 after edge 1; o_rsp0_valid pulse for one cycle after edge 3 with Result=7, zero=0; rsp1_valid stays 0.
- Contention: both valid from reset (req0 SUB 5/5, req1 ADD 1/1) -> req0 served first (Result=0, zero=1); req1 served next (Result=2); then, with both still valid, req0 is granted again, confirming alternation.
- Overflow pass-through: req1 ADD A=5'd15, B=5'd1 -> o_rsp1_valid with overflow=1 as reported by the ALU, Result=5'b10000.
- Reset mid-op: assert i_reset during WAIT -> no rsp strobe, all outputs 0 next cycle, priority=req0, ready0 high when req0 valid.
- Latency sweep: ALU_LAT=0 and ALU_LAT=3 with a model ALU -> capture at exactly ALU_LAT+1 edges after accept; correct result for each.
- Ready discipline: random valid toggling for 1000 cycles -> never both ready, no ready outside IDLE, every accept yields exactly one response strobe to the right requester.
